// File: rtl/pulse_period_monitor.sv
// rtl/pulse_period_monitor.sv - measures strobe period, locks on expected period, flags mismatch/timeout
module pulse_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk_in1,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] expected_period,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             err_mismatch,
  output logic             err_timeout,
  output logic [15:0]      pulse_count
);

  // match counter only needs to reach LOCK_COUNT; it is frozen while locked
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t           state;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic             evt;
  logic             hit;
  logic             expired;
  logic [MW-1:0]    match_nxt;

  // a held-high strobe counts once; the interval is compared against the target at each event
  assign evt       = pulse_in & ~pulse_q;
  assign hit       = (cnt == expected_period);
  assign expired   = (cnt == TO_VAL);
  assign match_nxt = match_cnt + MW'(1);

  // edge detector, interval counter, lock state machine and sticky status
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      state        <= IDLE;
      pulse_q      <= 1'b0;
      cnt          <= '0;
      match_cnt    <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
      pulse_count  <= '0;
    end else begin
      // edge history keeps tracking through clear so a straddling pulse is not re-detected
      pulse_q      <= pulse_in;
      period_valid <= 1'b0;
      if (clear) begin
        state        <= IDLE;
        cnt          <= '0;
        match_cnt    <= '0;
        locked       <= 1'b0;
        err_mismatch <= 1'b0;
        err_timeout  <= 1'b0;
        pulse_count  <= '0;
      end else begin
        if (evt && pulse_count != 16'hFFFF) begin
          pulse_count <= pulse_count + 16'd1;
        end
        case (state)
          IDLE: begin
            if (evt) begin
              state <= MEASURE;
              cnt   <= CNT_W'(1);
            end
          end
          MEASURE: begin
            if (evt) begin
              cnt          <= CNT_W'(1);
              period_out   <= cnt;
              period_valid <= 1'b1;
              if (hit) begin
                match_cnt <= match_nxt;
                if (match_nxt == LOCK_VAL) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end else if (expired) begin
              state       <= IDLE;
              cnt         <= '0;
              match_cnt   <= '0;
              err_timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LOCKED: begin
            if (evt) begin
              cnt          <= CNT_W'(1);
              period_out   <= cnt;
              period_valid <= 1'b1;
              if (!hit) begin
                state        <= MEASURE;
                locked       <= 1'b0;
                match_cnt    <= '0;
                err_mismatch <= 1'b1;
              end
            end else if (expired) begin
              state       <= IDLE;
              locked      <= 1'b0;
              cnt         <= '0;
              match_cnt   <= '0;
              err_timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb/tb_pulse_period_monitor.sv - self-checking bench for pulse_period_monitor
module tb_pulse_period_monitor;

  localparam int CNT_W = 8;

  logic             clk_in1 = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] expected_period = 8'd4;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             err_mismatch;
  logic             err_timeout;
  logic [15:0]      pulse_count;

  int errors = 0;
  int checks = 0;
  int sbq[$];
  int sb_exp;

  pulse_period_monitor #(.CNT_W(8), .LOCK_COUNT(3), .TIMEOUT(20)) dut (
    .clk_in1(clk_in1),
    .rst_n(rst_n),
    .pulse_in(pulse_in),
    .clear(clear),
    .expected_period(expected_period),
    .period_out(period_out),
    .period_valid(period_valid),
    .locked(locked),
    .err_mismatch(err_mismatch),
    .err_timeout(err_timeout),
    .pulse_count(pulse_count)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct {
    int lo;
    int hi;
    int push;
    int pc;
    int lk;
    int mis;
    int to;
    int ep;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic p, input logic c);
    @(negedge clk_in1);
    pulse_in = p;
    clear    = c;
    @(posedge clk_in1);
    #1;
  endtask

  task automatic flags(input string tag, input int pc, input int lk, input int mis, input int to);
    chk({tag, "_pc"}, int'(pulse_count), pc);
    chk({tag, "_locked"}, int'(locked), lk);
    chk({tag, "_mis"}, int'(err_mismatch), mis);
    chk({tag, "_to"}, int'(err_timeout), to);
  endtask

  task automatic apply(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      expected_period = CNT_W'(vecs[i].ep);
      for (int k = 0; k < vecs[i].lo; k++) tick(1'b0, 1'b0);
      if (vecs[i].push != 0) sbq.push_back(vecs[i].push);
      tick(1'b1, 1'b0);
      chk($sformatf("v%0d_valid", i), int'(period_valid), (vecs[i].push != 0) ? 1 : 0);
      for (int k = 1; k < vecs[i].hi; k++) tick(1'b1, 1'b0);
      flags($sformatf("v%0d", i), vecs[i].pc, vecs[i].lk, vecs[i].mis, vecs[i].to);
    end
  endtask

  // scoreboard: every period_valid must match the oldest expected period
  always @(posedge clk_in1) begin
    #1;
    if (rst_n && period_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_valid: got period_out=%0d expected no valid", period_out);
      end else begin
        sb_exp = sbq.pop_front();
        chk("sb_period", int'(period_out), sb_exp);
      end
    end
  end

  initial begin
    //          lo  hi push pc lk mis to ep
    vecs[0]  = '{1,  1, 0,  1, 0, 0, 0, 4};
    vecs[1]  = '{3,  1, 4,  2, 0, 0, 0, 4};
    vecs[2]  = '{3,  1, 4,  3, 0, 0, 0, 4};
    vecs[3]  = '{3,  1, 4,  4, 1, 0, 0, 4};
    vecs[4]  = '{4,  1, 5,  5, 0, 1, 0, 4};
    vecs[5]  = '{3,  1, 4,  6, 0, 1, 0, 4};
    vecs[6]  = '{3,  1, 4,  7, 0, 1, 0, 4};
    vecs[7]  = '{3,  1, 4,  8, 1, 1, 0, 4};
    vecs[8]  = '{2,  1, 0,  9, 0, 1, 1, 4};
    vecs[9]  = '{3,  1, 0,  1, 0, 0, 0, 4};
    vecs[10] = '{19, 1, 20, 2, 0, 0, 0, 4};
    vecs[11] = '{3,  1, 4,  3, 0, 0, 0, 4};
    vecs[12] = '{1,  3, 0,  1, 0, 0, 0, 8};
    vecs[13] = '{5,  3, 8,  2, 0, 0, 0, 8};
    vecs[14] = '{5,  3, 8,  3, 0, 0, 0, 8};
    vecs[15] = '{5,  3, 8,  4, 1, 0, 0, 8};

    // reset with toggling input
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("rst_period_out", int'(period_out), 0);
    chk("rst_valid", int'(period_valid), 0);
    flags("rst", 0, 0, 0, 0);
    tick(1'b0, 1'b0);
    rst_n = 1'b1;

    // lock, mismatch, relock
    apply(0, 7);

    // timeout 20 edges after the last event
    for (int k = 0; k < 19; k++) tick(1'b0, 1'b0);
    flags("to_pre", 8, 1, 1, 0);
    tick(1'b0, 1'b0);
    flags("to_hit", 8, 0, 1, 1);
    tick(1'b0, 1'b0);
    apply(8, 8);

    // clear in the same cycle as an event
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    chk("clr_valid", int'(period_valid), 0);
    flags("clr", 0, 0, 0, 0);
    tick(1'b0, 1'b0);

    // first event after clear, exact-timeout period, then normal period
    apply(9, 11);

    // wide pulses with period 8
    tick(1'b0, 1'b1);
    apply(12, 15);

    // constant-high input: one event then timeout
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
    sbq.push_back(8);
    tick(1'b1, 1'b0);
    flags("hi_evt", 5, 1, 0, 0);
    for (int k = 0; k < 19; k++) tick(1'b1, 1'b0);
    flags("hi_pre", 5, 1, 0, 0);
    tick(1'b1, 1'b0);
    flags("hi_to", 5, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);
    chk("hi_pc_hold", int'(pulse_count), 5);

    tick(1'b0, 1'b0);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
